// File: rtl/flexbex_ibex_instr_compressor.sv
// Streaming RV32 -> RVC re-encoder that packs the resulting halfword stream
// into little-endian 32-bit words (bits [15:0] carry the earlier halfword).
module flexbex_ibex_instr_compressor #(
    parameter bit EnableCompress = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_instr_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        err_o,
    output logic        idle_o,
    output logic [15:0] cnt_c_o
);

    localparam logic [6:0]  OpcOpImm = 7'b0010011;
    localparam logic [6:0]  OpcOp    = 7'b0110011;
    localparam logic [6:0]  OpcLoad  = 7'b0000011;
    localparam logic [6:0]  OpcStore = 7'b0100011;
    localparam logic [15:0] CNop     = 16'h0001;

    // Registered state
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic        hold_q;
    logic [15:0] hold_data_q;
    logic        err_q;
    logic [15:0] cnt_q;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;

    assign opcode = in_instr_i[6:0];
    assign rd     = in_instr_i[11:7];
    assign funct3 = in_instr_i[14:12];
    assign rs1    = in_instr_i[19:15];
    assign rs2    = in_instr_i[24:20];
    assign funct7 = in_instr_i[31:25];
    assign imm_i  = in_instr_i[31:20];
    assign imm_s  = {in_instr_i[31:25], in_instr_i[11:7]};

    // Field qualifiers used by the compression rules
    logic is_addi;
    logic is_add;
    logic is_lw;
    logic is_sw;
    logic imm_i_fits6;
    logic imm_i_zero;
    logic rd_zero;
    logic rs2_zero;
    logic rd_prime;
    logic rs1_prime;
    logic rs2_prime;
    logic lw_sp_off_ok;
    logic lw_off_ok;
    logic sw_sp_off_ok;
    logic sw_off_ok;

    assign is_addi = (opcode == OpcOpImm) && (funct3 == 3'b000);
    assign is_add  = (opcode == OpcOp) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_lw   = (opcode == OpcLoad) && (funct3 == 3'b010);
    assign is_sw   = (opcode == OpcStore) && (funct3 == 3'b010);

    // A 12-bit signed value lies in [-32,31] when bits [11:5] are all sign copies.
    assign imm_i_fits6 = (&imm_i[11:5]) || (~|imm_i[11:5]);
    assign imm_i_zero  = (imm_i == 12'd0);
    assign rd_zero     = (rd == 5'd0);
    assign rs2_zero    = (rs2 == 5'd0);
    assign rd_prime    = (rd[4:3] == 2'b01);
    assign rs1_prime   = (rs1[4:3] == 2'b01);
    assign rs2_prime   = (rs2[4:3] == 2'b01);

    // Non-negative word-aligned offsets: 0..252 for the SP forms, 0..124 otherwise.
    assign lw_sp_off_ok = (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'b00);
    assign lw_off_ok    = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
    assign sw_sp_off_ok = (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'b00);
    assign sw_off_ok    = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);

    logic        c_hit;
    logic [15:0] c_data;

    // NOTE: every output of a combinational block gets a default assignment
    // up front so no path through the if-chain can infer a latch.
    always_comb begin
        c_hit  = 1'b0;
        c_data = 16'h0000;
        if (is_addi && (rs1 == 5'd0) && !rd_zero && imm_i_fits6) begin
            // C.LI
            c_hit  = 1'b1;
            c_data = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (is_addi && (rs1 == rd) && imm_i_fits6 &&
                     ((!rd_zero && !imm_i_zero) || (rd_zero && imm_i_zero))) begin
            // C.ADDI; addi x0,x0,0 folds naturally into C.NOP
            c_hit  = 1'b1;
            c_data = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (is_add && (rs1 == 5'd0) && !rd_zero && !rs2_zero) begin
            // C.MV
            c_hit  = 1'b1;
            c_data = {4'b1000, rd, rs2, 2'b10};
        end else if (is_add && (rs1 == rd) && !rd_zero && !rs2_zero) begin
            // C.ADD
            c_hit  = 1'b1;
            c_data = {4'b1001, rd, rs2, 2'b10};
        end else if (is_lw && (rs1 == 5'd2) && !rd_zero && lw_sp_off_ok) begin
            // C.LWSP
            c_hit  = 1'b1;
            c_data = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        end else if (is_sw && (rs1 == 5'd2) && sw_sp_off_ok) begin
            // C.SWSP
            c_hit  = 1'b1;
            c_data = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end else if (is_lw && rd_prime && rs1_prime && lw_off_ok) begin
            // C.LW
            c_hit  = 1'b1;
            c_data = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (is_sw && rs2_prime && rs1_prime && sw_off_ok) begin
            // C.SW
            c_hit  = 1'b1;
            c_data = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
    end

    // Handshake and control
    logic legal;
    logic is_c;
    logic accept;
    logic flush_fire;

    assign legal      = (in_instr_i[1:0] == 2'b11);
    assign is_c       = EnableCompress && c_hit;
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    // Padding only when nothing else is using this edge and a half-word is waiting.
    assign flush_fire = flush_i && !accept && in_ready_o && hold_q;

    // NOTE: reset is synchronous (sampled only on the clock edge), and all
    // state uses non-blocking assignments so every register updates from the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            hold_q      <= 1'b0;
            hold_data_q <= 16'h0;
            err_q       <= 1'b0;
            cnt_q       <= 16'h0;
        end else begin
            err_q <= accept && !legal;

            // A draining word is cleared here; a load below the same edge wins.
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            if (accept && legal) begin
                if (is_c) begin
                    if (hold_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= {c_data, hold_data_q};
                        hold_q      <= 1'b0;
                    end else begin
                        hold_q      <= 1'b1;
                        hold_data_q <= c_data;
                    end
                    if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end else if (hold_q) begin
                    // Misaligned 32-bit word: low half completes the word, high half waits.
                    out_valid_q <= 1'b1;
                    out_data_q  <= {in_instr_i[15:0], hold_data_q};
                    hold_data_q <= in_instr_i[31:16];
                end else begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= in_instr_i;
                end
            end else if (flush_fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= {CNop, hold_data_q};
                hold_q      <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_o       = err_q;
    assign cnt_c_o     = cnt_q;
    assign idle_o      = !hold_q && !out_valid_q;

endmodule
